// File: rtl/led_pkg.sv
// Shared encodings for the LED indicator bank.
package led_pkg;

    localparam int unsigned MODE_W = 2;

    // Per-channel operating mode, taken straight from the mode input bus
    typedef enum logic [MODE_W-1:0] {
        LED_OFF     = 2'b00,
        LED_STRETCH = 2'b01,
        LED_BLINK   = 2'b10,
        LED_ON      = 2'b11
    } led_mode_e;

    // Stretch-mode channel state
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_GAP  = 2'b10
    } led_state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Shared millisecond timebase and PWM phase counter for all LED channels.
module led_tick_gen #(
    parameter int unsigned TICK_CYC = 125_000,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ms_tick_c,
    output logic [PWM_BITS-1:0] pwm_nxt_c
);

    localparam int unsigned PRE_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

    // Free-running prescaler with a one-cycle tick at wrap; PWM phase wraps naturally
    always_comb begin
        presc_d   = presc_q + PRE_W'(1);
        ms_tick_c = (presc_q == PRE_W'(TICK_CYC - 1));
        if (ms_tick_c) begin
            presc_d = '0;
        end
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end

    // Timebase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // Channels gate their registered LED against the PWM phase of the coming cycle
    assign pwm_nxt_c = pwm_cnt_d;

endmodule

// File: rtl/led_indicator_bank.sv
// Multi-channel LED driver: off / stretch / blink / on per channel with PWM dimming.
module led_indicator_bank
    import led_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 125_000_000,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned STRETCH_MS = 100,
    parameter int unsigned GAP_MS     = 50,
    parameter int unsigned BLINK_MS   = 250,
    parameter int unsigned PWM_BITS   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0]            strobe,
    input  logic [MODE_W*N_CH-1:0]     mode,
    input  logic [PWM_BITS*N_CH-1:0]   bright,
    output logic [N_CH-1:0]            led,
    output logic [N_CH-1:0]            busy
);

    localparam int unsigned TICK_CYC = CLK_HZ / 1000;
    localparam int unsigned CNT_MAX  = (STRETCH_MS > GAP_MS) ? STRETCH_MS : GAP_MS;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned BLK_W    = $clog2(BLINK_MS + 1);

    logic                ms_tick_c;
    logic [PWM_BITS-1:0] pwm_nxt_c;

    led_tick_gen #(
        .TICK_CYC (TICK_CYC),
        .PWM_BITS (PWM_BITS)
    ) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .ms_tick_c (ms_tick_c),
        .pwm_nxt_c (pwm_nxt_c)
    );

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch

        led_mode_e           mode_c;
        logic [PWM_BITS-1:0] bright_c;

        led_mode_e           mode_q;
        led_state_e          state_q, state_d;
        logic [CNT_W-1:0]    cnt_q, cnt_d;
        logic [BLK_W-1:0]    bcnt_q, bcnt_d;
        logic                pending_q, pending_d;
        logic                phase_q, phase_d;
        logic                raw_d;
        logic                led_q, led_d;
        logic                busy_q, busy_d;

        assign mode_c   = led_mode_e'(mode[MODE_W*ch +: MODE_W]);
        assign bright_c = bright[PWM_BITS*ch +: PWM_BITS];

        // Next-state for the stretch FSM and blink phase, plus registered output drive
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            bcnt_d    = bcnt_q;
            pending_d = pending_q;
            phase_d   = phase_q;
            raw_d     = 1'b0;
            led_d     = 1'b0;
            busy_d    = 1'b0;

            if (mode_c != mode_q) begin
                // Any mode change restarts the channel; blink always opens with a lit phase
                state_d   = ST_IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
                phase_d   = 1'b1;
                bcnt_d    = BLK_W'(BLINK_MS);
            end else if (mode_c == LED_STRETCH) begin
                case (state_q)
                    ST_IDLE: begin
                        if (strobe[ch]) begin
                            state_d = ST_ON;
                            cnt_d   = CNT_W'(STRETCH_MS);
                        end
                    end
                    ST_ON: begin
                        // Retrigger takes priority over a coincident tick
                        if (strobe[ch]) begin
                            cnt_d = CNT_W'(STRETCH_MS);
                        end else if (ms_tick_c) begin
                            if (cnt_q <= CNT_W'(1)) begin
                                state_d   = ST_GAP;
                                cnt_d     = CNT_W'(GAP_MS);
                                pending_d = 1'b0;
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                    end
                    ST_GAP: begin
                        // Strobes during the gap are remembered and replayed when it ends
                        if (strobe[ch]) begin
                            pending_d = 1'b1;
                        end
                        if (ms_tick_c) begin
                            if (cnt_q <= CNT_W'(1)) begin
                                pending_d = 1'b0;
                                if (pending_q || strobe[ch]) begin
                                    state_d = ST_ON;
                                    cnt_d   = CNT_W'(STRETCH_MS);
                                end else begin
                                    state_d = ST_IDLE;
                                    cnt_d   = '0;
                                end
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        pending_d = 1'b0;
                    end
                endcase
            end else if (mode_c == LED_BLINK) begin
                if (ms_tick_c) begin
                    if (bcnt_q <= BLK_W'(1)) begin
                        phase_d = ~phase_q;
                        bcnt_d  = BLK_W'(BLINK_MS);
                    end else begin
                        bcnt_d = bcnt_q - BLK_W'(1);
                    end
                end
            end

            case (mode_c)
                LED_OFF:     raw_d = 1'b0;
                LED_STRETCH: raw_d = (state_d == ST_ON);
                LED_BLINK:   raw_d = phase_d;
                LED_ON:      raw_d = 1'b1;
                default:     raw_d = 1'b0;
            endcase

            led_d  = raw_d && (pwm_nxt_c <= bright_c);
            busy_d = (mode_c == LED_STRETCH) && (state_d != ST_IDLE);
        end

        // Channel state and output registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_q    <= LED_OFF;
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                bcnt_q    <= '0;
                pending_q <= 1'b0;
                phase_q   <= 1'b0;
                led_q     <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                mode_q    <= mode_c;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                bcnt_q    <= bcnt_d;
                pending_q <= pending_d;
                phase_q   <= phase_d;
                led_q     <= led_d;
                busy_q    <= busy_d;
            end
        end

        assign led[ch]  = led_q;
        assign busy[ch] = busy_q;

    end

endmodule

// File: tb/tb_led_indicator_bank.sv
// Directed bench for led_indicator_bank (10 cycles per ms tick, 2 channels).
module tb_led_indicator_bank;

    logic       clk;
    logic       rst_n;
    logic [1:0] strobe;
    logic [3:0] mode;
    logic [3:0] bright;
    logic [1:0] led;
    logic [1:0] busy;

    int checks;
    int errors;
    int cyc;
    logic l1_bad;

    led_indicator_bank #(
        .CLK_HZ     (10_000),
        .N_CH       (2),
        .STRETCH_MS (5),
        .GAP_MS     (2),
        .BLINK_MS   (3),
        .PWM_BITS   (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (strobe),
        .mode   (mode),
        .bright (bright),
        .led    (led),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release: equals the prescaler / PWM phase of the current cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Channel 1 is kept in off mode for the whole run and must never light
    always @(negedge clk) begin
        if (rst_n && (led[1] || busy[1])) l1_bad = 1'b1;
    end

    initial begin
        #200_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "bench timed out");
    end

    typedef struct packed {
        logic [1:0] m;
        logic [1:0] b;
        logic       s;
        logic       el;
        logic       eb;
    } vec_t;

    localparam int NV = 35;
    vec_t vt [NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // First cycle after t whose prescaler value is 9 (tick cycle)
    function automatic int tick_after(input int t);
        int a;
        a = t + 1;
        while (a % 10 != 9) a++;
        return a;
    endfunction

    // ON length for a pulse started (from IDLE) by a strobe in cycle t: ends on the fifth tick
    function automatic int exp_on(input int t);
        return tick_after(t) + 40 - t;
    endfunction

    task automatic run_len(input logic lvl, input int lim, output int n);
        n = 0;
        while (led[0] == lvl && n < lim) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy[0] || led[0]) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(name, int'(busy[0]), 0);
    endtask

    task automatic pulse0();
        strobe = 2'b01;
        @(negedge clk);
        strobe = 2'b00;
    endtask

    task automatic setv(input int i, input logic [1:0] m, input logic [1:0] b,
                        input logic s, input logic el, input logic eb);
        vt[i] = '{m: m, b: b, s: s, el: el, eb: eb};
    endtask

    initial begin
        int t, s, n, lo, lows, rises, gap_led, m, ridx, rl, busy_bad;
        int runs [4];
        logic prev;

        checks = 0;
        errors = 0;
        l1_bad = 1'b0;

        // PWM / mode table; entry i is checked in a cycle whose pwm_cnt is i%4
        for (int i = 0; i < 4; i++)  setv(i,      2'b11, 2'd1, 1'b0, (i % 4) <= 1, 1'b0);
        for (int i = 4; i < 8; i++)  setv(i,      2'b11, 2'd1, 1'b1, (i % 4) <= 1, 1'b0);
        for (int i = 8; i < 12; i++) setv(i,      2'b11, 2'd0, 1'b0, (i % 4) == 0, 1'b0);
        for (int i = 12; i < 16; i++) setv(i,     2'b11, 2'd3, 1'b0, 1'b1, 1'b0);
        for (int i = 16; i < 20; i++) setv(i,     2'b11, 2'd2, 1'b0, (i % 4) <= 2, 1'b0);
        for (int i = 20; i < 24; i++) setv(i,     2'b00, 2'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 24; i < 28; i++) setv(i,     2'b01, 2'd3, 1'b0, 1'b0, 1'b0);
        setv(28, 2'b01, 2'd3, 1'b1, 1'b1, 1'b1);
        setv(29, 2'b01, 2'd1, 1'b0, 1'b1, 1'b1);
        setv(30, 2'b01, 2'd1, 1'b0, 1'b0, 1'b1);
        setv(31, 2'b01, 2'd3, 1'b0, 1'b1, 1'b1);
        setv(32, 2'b00, 2'd3, 1'b0, 1'b0, 1'b0);
        setv(33, 2'b01, 2'd3, 1'b0, 1'b0, 1'b0);
        setv(34, 2'b01, 2'd3, 1'b0, 1'b0, 1'b0);

        // Reset
        rst_n  = 1'b0;
        strobe = 2'b00;
        mode   = 4'b0000;
        bright = 4'b1111;
        repeat (3) @(negedge clk);
        check("rst_led", int'(led), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Single stretch pulse: on at t+1, ON length tied to tick phase, then a gap
        mode = 4'b0001;
        repeat (3) @(negedge clk);
        t = cyc;
        pulse0();
        check("a_led_t1", int'(led[0]), 1);
        check("a_busy_on", int'(busy[0]), 1);
        run_len(1'b1, 200, n);
        check("a_on_len", n, exp_on(t));
        check("a_busy_gap", int'(busy[0]), 1);
        n = 0;
        gap_led = 0;
        while (busy[0] && n < 100) begin
            if (led[0]) gap_led++;
            n++;
            @(negedge clk);
        end
        check_rng("a_gap_len", n, 11, 20);
        check("a_gap_dark", gap_led, 0);
        repeat (5) @(negedge clk);
        check("a_idle_led", int'(led[0]), 0);

        // Retrigger every 30 cycles keeps the LED lit; then one fall and a gap
        t = cyc;
        lows = 0;
        for (int c = 0; c <= 180; c++) begin
            strobe = (c % 30 == 0) ? 2'b01 : 2'b00;
            @(negedge clk);
            if (!led[0]) lows++;
        end
        strobe = 2'b00;
        check("b_continuous", lows, 0);
        run_len(1'b1, 200, n);
        check("b_tail_len", n, exp_on(t + 180));
        n = 0;
        while (busy[0] && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_rng("b_gap_len", n, 11, 20);
        rises = 0;
        prev = led[0];
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (led[0] && !prev) rises++;
            prev = led[0];
        end
        check("b_one_fall", rises, 0);

        // Strobe colliding with a tick while ON reloads the full count
        t = cyc;
        pulse0();
        while ((cyc % 10) != 9 || cyc <= t + 2) @(negedge clk);
        s = cyc;
        pulse0();
        run_len(1'b1, 200, n);
        check("c_collide_len", n, 50);

        // Strobe inside the gap: gap kept in full, then a full pending pulse
        lo = 0;
        for (int i = 0; i < 8; i++) begin
            if (!led[0]) lo++;
            strobe = (i == 5) ? 2'b01 : 2'b00;
            @(negedge clk);
        end
        strobe = 2'b00;
        run_len(1'b0, 100, n);
        check("c_gap_full", lo + n, 20);
        run_len(1'b1, 200, n);
        check("c_pending_on", n, 50);
        wait_idle("c_idle");

        // Blink: starts lit, 30/30 steady square wave, strobes ignored, never busy
        m = cyc;
        mode = 4'b0010;
        @(negedge clk);
        check("d_start_hi", int'(led[0]), 1);
        ridx = 0;
        rl = 0;
        prev = 1'b1;
        busy_bad = 0;
        for (int i = 0; i < 130; i++) begin
            strobe = (i % 7 == 0) ? 2'b01 : 2'b00;
            if (busy[0]) busy_bad++;
            if (led[0] == prev) begin
                rl++;
            end else begin
                if (ridx < 4) runs[ridx] = rl;
                ridx++;
                rl = 1;
                prev = led[0];
            end
            @(negedge clk);
        end
        strobe = 2'b00;
        check("d_run_count", (ridx >= 4) ? 1 : 0, 1);
        if (ridx >= 4) begin
            check("d_first_hi", runs[0], tick_after(m) + 20 - m);
            check("d_lo1", runs[1], 30);
            check("d_hi2", runs[2], 30);
            check("d_lo2", runs[3], 30);
        end
        check("d_busy", busy_bad, 0);

        // PWM duty and mode table, aligned to pwm_cnt phase
        while ((cyc % 4) != 3) @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            mode   = {2'b00, vt[i].m};
            bright = {2'b11, vt[i].b};
            strobe = {1'b0, vt[i].s};
            @(negedge clk);
            if (led[0] != vt[i].el || busy[0] != vt[i].eb)
                $display("  at table entry %0d", i);
            check("e_tbl_led", int'(led[0]), int'(vt[i].el));
            check("e_tbl_busy", int'(busy[0]), int'(vt[i].eb));
        end
        strobe = 2'b00;
        bright = 4'b1111;
        mode   = 4'b0001;
        repeat (2) @(negedge clk);

        // Async reset in the middle of a pulse
        pulse0();
        repeat (10) @(negedge clk);
        check("f_pre_led", int'(led[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("f_async_led", int'(led), 0);
        check("f_async_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("f_post_led", int'(led), 0);
        check("f_post_busy", int'(busy), 0);
        @(negedge clk);
        t = cyc;
        pulse0();
        check("f_restart_t1", int'(led[0]), 1);
        run_len(1'b1, 200, n);
        check("f_restart_len", n, exp_on(t));
        wait_idle("f_idle");

        // Mode 01 -> 00 -> 01 mid-pulse drops to IDLE; next strobe gives a full pulse
        pulse0();
        repeat (10) @(negedge clk);
        mode = 4'b0000;
        @(negedge clk);
        check("g_off_led", int'(led[0]), 0);
        check("g_off_busy", int'(busy[0]), 0);
        mode = 4'b0001;
        @(negedge clk);
        check("g_idle_led", int'(led[0]), 0);
        check("g_idle_busy", int'(busy[0]), 0);
        repeat (3) @(negedge clk);
        check("g_still_idle", int'(busy[0]), 0);
        t = cyc;
        pulse0();
        run_len(1'b1, 200, n);
        check("g_full_len", n, exp_on(t));
        wait_idle("g_idle");

        check("ch1_quiet", int'(l1_bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_indicator_bank.md
Name: led_indicator_bank

Overview:
Multi-channel successor to the single-LED pulse stretcher. It drives N_CH board LEDs from one shared millisecond timebase. Each channel has a selectable mode (off / stretch / blink / on), strobe retrigger, a guaranteed visible off-gap between back-to-back events, and per-channel PWM dimming. It sits between the status/event logic (classifier-done, error and link strobes) and the top-level LED pins.

Parameters:
CLK_HZ, 125_000_000, input clock frequency; TICK_CYC = CLK_HZ/1000 cycles per ms tick
N_CH, 4, number of LED channels
STRETCH_MS, 100, on-time per stretch event, in ms ticks (>=1)
GAP_MS, 50, forced off-time after a stretch pulse, in ms ticks (>=1)
BLINK_MS, 250, half-period of blink mode, in ms ticks (>=1)
PWM_BITS, 4, brightness resolution

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
strobe  in  N_CH  per-channel event pulse, 1 cycle or level; each high cycle counts as an event
mode  in  2*N_CH  channel i uses bits [2i+1:2i]; 00 off, 01 stretch, 10 blink, 11 on
bright  in  PWM_BITS*N_CH  channel i uses bits [PWM_BITS*(i+1)-1:PWM_BITS*i]; duty level
led  out  N_CH  registered LED drive
busy  out  N_CH  channel i is in ON or GAP (stretch mode), registered

Behaviour:
- Reset: led=0, busy=0, all channel FSMs IDLE, pending=0, prescaler=0, pwm_cnt=0, blink phase=0.
- Timebase: a prescaler counts 0..TICK_CYC-1 and asserts ms_tick for 1 cycle at wrap. It is free-running and never restarted. pwm_cnt (PWM_BITS wide) increments every cycle and wraps.
- Per-channel stretch FSM (mode=01), states IDLE/ON/GAP; ms counter sized by $clog2 of max(STRETCH_MS,GAP_MS)+1.
  - IDLE: strobe -> ON, cnt=STRETCH_MS.
  - ON: each ms_tick decrements cnt. A strobe reloads cnt=STRETCH_MS (retrigger). A strobe and ms_tick in the same cycle -> reload wins. At cnt reaching 0 -> GAP, cnt=GAP_MS, pending=0.
  - GAP: led off. A strobe sets pending=1; it is not lost. At cnt reaching 0: pending -> ON with cnt=STRETCH_MS, else IDLE.
  - A strobe in IDLE at cycle t gives led_raw=1 at t+1, before PWM gating.
  - ON duration is in (STRETCH_MS-1, STRETCH_MS] ms because the tick phase is free. GAP follows the same rule.
- Blink (10): phase toggles every BLINK_MS ms ticks, and on entry starts at phase=1 (on) with a fresh count. Strobes are ignored. busy=0.
- On (11): led_raw=1. Off (00): led_raw=0.
- Mode changes: any change of a channel's mode forces its FSM to IDLE, clears pending and count, and is applied on the next cycle. Other channels are unaffected.
- Output: led[i] = led_raw[i] & (pwm_cnt <= bright[i]), registered. bright = all-ones means 100% duty; bright=0 means 1/2^PWM_BITS duty.
- Async reset mid-pulse returns everything to reset values immediately. After release, the first strobe behaves as from IDLE.
- All arithmetic is unsigned. Counters saturate at 0 and never underflow.

Decomposition:
- Package led_pkg: mode encodings (LED_OFF=2'b00, LED_STRETCH=2'b01, LED_BLINK=2'b10, LED_ON=2'b11) and the state encoding (IDLE/ON/GAP).
- Sub-module led_tick_gen: prescaler plus pwm_cnt, instantiated once and shared by all channels.
- Per-channel logic goes in a generate loop inside led_indicator_bank.

Test Plan (CLK_HZ=10_000 so TICK_CYC=10; N_CH=2, STRETCH_MS=5, GAP_MS=2, BLINK_MS=3, PWM_BITS=2; bright=3 unless stated):
- mode0=01, 1-cycle strobe0 at t -> led[0]=1 from t+1; high for 41..50 cycles; then 11..20 cycles low; busy[0] falls at end of GAP; led[1] stays 0.
- Strobe0 every 30 cycles for 200 cycles -> led[0] continuously high (retrigger). Then no strobes -> exactly one falling edge, then GAP.
- Strobe0 during GAP -> led[0] low for the full GAP, then a new ON pulse of 41..50 cycles (pending honoured). Also check a strobe colliding with an ms_tick in ON -> cnt reloaded to 5.
- mode0=10 -> led[0] square wave of 30 cycles high / 30 cycles low starting high; strobes have no effect; busy[0]=0.
- mode0=11, bright0=1 -> led[0] duty 2/4 (pattern tied to pwm_cnt<=1); bright0=0 -> 1/4 duty; mode0=00 -> led[0]=0.
- rst_n low for 3 cycles mid-ON -> led=0, busy=0 asynchronously. Mode switch 01->00->01 mid-ON -> channel IDLE, and the next strobe restarts a full pulse.
